// File: rtl/sorun_denetleyici_if.sv
// Decode/writeback <-> hazard controller bundle. The decode/writeback side uses the
// master modport; the controller uses the slave modport.
interface sorun_denetleyici_if #(
  parameter int SAYAC_BIT = 32
);
  logic                 coz_gecerli_i;
  logic [4:0]           rs1_adres_i;
  logic                 rs1_kullan_i;
  logic [4:0]           rs2_adres_i;
  logic                 rs2_kullan_i;
  logic [4:0]           rd_adres_i;
  logic                 rd_yaz_i;
  logic                 uzun_gecikme_i;
  logic                 temizle_i;
  logic                 gy_gecerli_i;
  logic [4:0]           gy_adres_i;

  logic                 yurut_gecerli_o;
  logic                 durdur_o;
  logic                 bolucu_basla_o;
  logic                 bolucu_mesgul_o;
  logic                 bolucu_bitti_o;
  logic [SAYAC_BIT-1:0] durma_sayaci_o;

  modport master (
    output coz_gecerli_i, rs1_adres_i, rs1_kullan_i, rs2_adres_i, rs2_kullan_i,
           rd_adres_i, rd_yaz_i, uzun_gecikme_i, temizle_i, gy_gecerli_i, gy_adres_i,
    input  yurut_gecerli_o, durdur_o, bolucu_basla_o, bolucu_mesgul_o,
           bolucu_bitti_o, durma_sayaci_o
  );

  modport slave (
    input  coz_gecerli_i, rs1_adres_i, rs1_kullan_i, rs2_adres_i, rs2_kullan_i,
           rd_adres_i, rd_yaz_i, uzun_gecikme_i, temizle_i, gy_gecerli_i, gy_adres_i,
    output yurut_gecerli_o, durdur_o, bolucu_basla_o, bolucu_mesgul_o,
           bolucu_bitti_o, durma_sayaci_o
  );
endinterface

// File: rtl/sorun_denetleyici.sv
// Issue/hazard controller: register scoreboard, shared-divider busy FSM, stall counter.
// Optional macro ILERI_YONLENDIRME_EN: registers retiring this cycle are not hazards.
module sorun_denetleyici #(
  parameter int BOLME_GECIKME = 34,
  parameter int SAYAC_BIT     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sorun_denetleyici_if.slave    bus
);

  localparam int SG_BIT = (BOLME_GECIKME > 2) ? $clog2(BOLME_GECIKME - 1) : 1;
  localparam logic [SG_BIT-1:0] SAYAC_YUKLE = SG_BIT'(BOLME_GECIKME - 2);

  typedef enum logic [1:0] {
    BOSTA,
    MESGUL,
    BITTI
  } durum_e;

  logic [31:0]          bekleyen_q, bekleyen_d;
  durum_e               durum_q, durum_d;
  logic [SG_BIT-1:0]    sayac_q, sayac_d;
  logic                 mesgul_q, bitti_q;
  logic [SAYAC_BIT-1:0] durma_sayaci_q, durma_sayaci_d;

  logic [31:0] gy_maske;
  logic [31:0] etkin_bekleyen;
  logic        tehlike;
  logic        yurut;
  logic        durdur;
  logic        basla;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    gy_maske = '0;
    if (bus.gy_gecerli_i) gy_maske[bus.gy_adres_i] = 1'b1;
    gy_maske[0] = 1'b0;
  end

`ifdef ILERI_YONLENDIRME_EN
  assign etkin_bekleyen = bekleyen_q & ~gy_maske;
`else
  assign etkin_bekleyen = bekleyen_q;
`endif

  // Bit 0 of the scoreboard is never set, so x0 can never raise a hazard.
  always_comb begin
    tehlike = 1'b0;
    if (bus.rs1_kullan_i && etkin_bekleyen[bus.rs1_adres_i]) tehlike = 1'b1;
    if (bus.rs2_kullan_i && etkin_bekleyen[bus.rs2_adres_i]) tehlike = 1'b1;
    if (bus.rd_yaz_i     && etkin_bekleyen[bus.rd_adres_i])  tehlike = 1'b1;
    if (bus.uzun_gecikme_i && (durum_q != BOSTA))            tehlike = 1'b1;
  end

  assign yurut  = bus.coz_gecerli_i & ~tehlike & ~bus.temizle_i & ~rst_i;
  assign durdur = bus.coz_gecerli_i &  tehlike & ~bus.temizle_i & ~rst_i;
  assign basla  = yurut & bus.uzun_gecikme_i;

  // Clear before set: a writer issued the same cycle its rd retires stays pending.
  always_comb begin
    bekleyen_d = bekleyen_q & ~gy_maske;
    if (yurut && bus.rd_yaz_i) bekleyen_d[bus.rd_adres_i] = 1'b1;
    bekleyen_d[0] = 1'b0;
  end

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    unique case (durum_q)
      BOSTA: begin
        if (basla) begin
          durum_d = MESGUL;
          sayac_d = SAYAC_YUKLE;
        end
      end
      MESGUL: begin
        if (sayac_q == '0) durum_d = BITTI;
        else               sayac_d = sayac_q - 1'b1;
      end
      BITTI:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    durma_sayaci_d = durma_sayaci_q;
    if (durdur && !(&durma_sayaci_q)) durma_sayaci_d = durma_sayaci_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bekleyen_q     <= '0;
      durma_sayaci_q <= '0;
    end else begin
      bekleyen_q     <= bekleyen_d;
      durma_sayaci_q <= durma_sayaci_d;
    end
  end

  // Divider FSM with its status outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q  <= BOSTA;
      sayac_q  <= '0;
      mesgul_q <= 1'b0;
      bitti_q  <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      sayac_q  <= sayac_d;
      mesgul_q <= (durum_d != BOSTA);
      bitti_q  <= (durum_d == BITTI);
    end
  end

  // Registered flags are masked so all 1-bit outputs read low throughout reset.
  assign bus.yurut_gecerli_o = yurut;
  assign bus.durdur_o        = durdur;
  assign bus.bolucu_basla_o  = basla;
  assign bus.bolucu_mesgul_o = mesgul_q & ~rst_i;
  assign bus.bolucu_bitti_o  = bitti_q  & ~rst_i;
  assign bus.durma_sayaci_o  = durma_sayaci_q;

endmodule
